// File: rtl/afe_rx_pkg.sv
// Shared definitions for the receive-side PRBS21 checker.
package afe_rx_pkg;

  // PRBS21 recurrence: s[n] = s[n-PRBS_LEN] ^ s[n-1-PRBS_TAP]
  localparam int PRBS_LEN = 21;
  localparam int PRBS_TAP = 1;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear takes priority, then the same-cycle increment applies.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             emu_clk,
  input  logic             emu_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // Count register: clr zeros first, so a coincident inc leaves the value at 1.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? WIDTH'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prbs_rx_checker.sv
// Slices the AFE output, self-synchronizes to PRBS21 and counts bits/errors.
//
//   state  | meaning
//   SEED   | filling the 21-bit history, no comparisons
//   ACQ    | counting consecutive correct predictions toward lock
//   LOCKED | counting bits and errors, watching the error window
module prbs_rx_checker
  import afe_rx_pkg::*;
#(
  parameter int IN_WIDTH    = 18,
  parameter int CNT_WIDTH   = 32,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_WIN  = 256,
  parameter int UNLOCK_ERRS = 16
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic                 clk_en,
  input  logic [IN_WIDTH-1:0]  rx_in,
  input  logic [IN_WIDTH-1:0]  thresh,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] bit_cnt,
  output logic [1:0]           state
);

  localparam int SW = $clog2(PRBS_LEN);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(UNLOCK_WIN);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [SW-1:0] SEED_LAST  = SW'(PRBS_LEN - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(UNLOCK_WIN - 1);
  localparam logic [EW-1:0] ERR_LIMIT  = EW'(UNLOCK_ERRS);

  rx_state_t             state_q, state_d;
  logic [PRBS_LEN-1:0]   hist_q, hist_d;
  logic [SW-1:0]         seed_q, seed_d;
  logic [MW-1:0]         match_q, match_d;
  logic [WW-1:0]         win_q, win_d;
  logic [EW-1:0]         werr_q, werr_d, werr_nx;
  logic                  pulse_q, pulse_d;
  logic                  bit_s, pred, mism;
  logic                  cnt_bit, cnt_err;

  // Next-state, history shift and window bookkeeping for one sample.
  always_comb begin
    bit_s   = $signed(rx_in) >= $signed(thresh);
    pred    = hist_q[PRBS_LEN-1] ^ hist_q[PRBS_TAP];
    mism    = bit_s ^ pred;
    state_d = state_q;
    hist_d  = hist_q;
    seed_d  = seed_q;
    match_d = match_q;
    win_d   = clr ? '0 : win_q;
    werr_d  = clr ? '0 : werr_q;
    werr_nx = werr_d;
    pulse_d = 1'b0;
    cnt_bit = 1'b0;
    cnt_err = 1'b0;
    if (clk_en) begin
      // Received bits always feed the history so the checker re-seeds itself.
      hist_d = {hist_q[PRBS_LEN-2:0], bit_s};
      unique case (state_q)
        SEED: begin
          if (seed_q == SEED_LAST) begin
            state_d = ACQ;
            seed_d  = '0;
            match_d = '0;
          end else begin
            seed_d = seed_q + SW'(1);
          end
        end
        ACQ: begin
          if (mism) begin
            match_d = '0;
          end else begin
            match_d = match_q + MW'(1);
            if (match_q == MATCH_LAST) state_d = LOCKED;
          end
        end
        LOCKED: begin
          cnt_bit = 1'b1;
          cnt_err = mism;
          pulse_d = mism;
          werr_nx = werr_d + EW'(mism);
          if (werr_nx == ERR_LIMIT) begin
            state_d = SEED;
            seed_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_d == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_d + WW'(1);
            werr_d = werr_nx;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q <= SEED;
      hist_q  <= '0;
      seed_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      seed_q  <= seed_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      pulse_q <= pulse_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .inc     (cnt_err),
    .clr     (clr),
    .q       (err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_cnt (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .inc     (cnt_bit),
    .clr     (clr),
    .q       (bit_cnt)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = pulse_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Randomized bench for prbs_rx_checker with a sample-level behavioural model.
module tb_prbs_rx_checker;

  localparam int IW = 18;
  localparam int CW = 32;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  logic          emu_clk = 1'b0;
  logic          emu_rst, clk_en, clr;
  logic [IW-1:0] rx_in, thresh;
  logic          locked, err_pulse;
  logic [CW-1:0] err_cnt, bit_cnt;
  logic [1:0]    state;

  prbs_rx_checker #(
    .IN_WIDTH(IW), .CNT_WIDTH(CW), .LOCK_CNT(64), .UNLOCK_WIN(256), .UNLOCK_ERRS(16)
  ) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .clk_en    (clk_en),
    .rx_in     (rx_in),
    .thresh    (thresh),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt),
    .state     (state)
  );

  always #5 emu_clk = ~emu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the checker, advanced once per driven cycle
  int     ms, m_seed, m_match, m_win, m_werr;
  longint m_err, m_bits;
  bit     m_pulse;
  bit     hist[$];
  bit     m_valid = 1'b0;

  // observation bookkeeping
  int     sample_idx = 0;
  int     phase_base = 0;
  int     rise_at = -1;
  bit     prev_locked = 1'b0;
  int     pulse_at[$];
  int     max_state = 0;
  bit     ever_locked = 1'b0;
  logic [20:0] tx_sr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; m_seed = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_err = 0; m_bits = 0; m_pulse = 1'b0;
    hist.delete();
    for (int i = 0; i < 21; i++) hist.push_back(1'b0);
    m_valid = 1'b1;
  endtask

  task automatic model_step(input bit en, input bit b, input bit c);
    bit p, m;
    m_pulse = 1'b0;
    if (c) begin m_err = 0; m_bits = 0; m_win = 0; m_werr = 0; end
    if (!en) return;
    // hist[0] is the bit 21 samples ago, hist[19] the bit 2 samples ago
    p = hist[0] ^ hist[19];
    m = b ^ p;
    case (ms)
      0: begin
        m_seed++;
        if (m_seed == 21) begin ms = 1; m_seed = 0; m_match = 0; end
      end
      1: begin
        if (m) m_match = 0; else m_match++;
        if (m_match == 64) ms = 2;
      end
      default: begin
        if (m_bits < SAT) m_bits++;
        if (m) begin
          if (m_err < SAT) m_err++;
          m_pulse = 1'b1;
          m_werr++;
        end
        m_win++;
        if (m_werr == 16) begin ms = 0; m_seed = 0; m_win = 0; m_werr = 0; end
        else if (m_win == 256) begin m_win = 0; m_werr = 0; end
      end
    endcase
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  // compare DUT against the model, away from the rising edge
  task automatic check_outputs();
    if (!m_valid) return;
    chk("state", state, ms);
    chk("locked", locked, (ms == 2));
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_cnt", err_cnt, m_err);
    chk("bit_cnt", bit_cnt, m_bits);
    if (locked === 1'b1 && !prev_locked) rise_at = sample_idx - phase_base;
    prev_locked = (locked === 1'b1);
    if (err_pulse === 1'b1) pulse_at.push_back(sample_idx);
    if (locked === 1'b1) ever_locked = 1'b1;
    if (int'(state) > max_state) max_state = int'(state);
  endtask

  task automatic set_rx(input bit b);
    int th, d, v;
    if ($urandom_range(0, 1) == 0) th = 0;
    else th = int'($urandom_range(0, 4000)) - 2000;
    d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3000));
    if (th == 0 && $urandom_range(0, 1) == 1) v = b ? 4096 : -4096;
    else v = b ? th + d : th - 1 - d;
    thresh = th[IW-1:0];
    rx_in  = v[IW-1:0];
  endtask

  task automatic cycle(input bit rst, input bit en, input bit b, input bit c);
    @(negedge emu_clk);
    check_outputs();
    emu_rst = rst;
    clk_en  = en;
    clr     = c;
    set_rx(b);
    if (rst) model_reset();
    else model_step(en, b, c);
    if (en && !rst) sample_idx++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'(($urandom_range(0, 1))), 1'b0);
  endtask

  task automatic next_tx(output bit b);
    b = tx_sr[6];
    tx_sr = {tx_sr[19:0], tx_sr[20] ^ tx_sr[1]};
  endtask

  // n samples of the transmitted PRBS, clk_en on every second cycle
  task automatic run_clean(input int n, input bit invert);
    bit b;
    for (int i = 0; i < n; i++) begin
      next_tx(b);
      cycle(1'b0, 1'b1, b ^ invert, 1'b0);
      idle();
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0);
  endtask

  initial begin
    bit     b;
    int     k;
    longint e0, s_err, s_bits;
    emu_rst = 1'b1; clk_en = 1'b0; clr = 1'b0; rx_in = '0; thresh = '0;
    tx_sr = '1;

    // reset
    do_reset();
    idle();
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_err_pulse", err_pulse, 0);

    // clean lock: 21 seed + 64 matches
    phase_base = sample_idx; rise_at = -1;
    run_clean(85, 1'b0);
    idle();
    chk("lock_sample", rise_at, 85);
    run_clean(1000, 1'b0);
    idle();
    chk("clean_bit_cnt", bit_cnt, 1000);
    chk("clean_err_cnt", err_cnt, 0);

    // single channel error triples into k, k+2, k+21
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_clean(5, 1'b0);
    pulse_at.delete();
    next_tx(b);
    cycle(1'b0, 1'b1, ~b, 1'b0);
    k = sample_idx;
    idle();
    run_clean(40, 1'b0);
    idle();
    chk("single_err_cnt", err_cnt, 3);
    chk("single_pulses", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      chk("pulse_k", pulse_at[0] - k, 0);
      chk("pulse_k2", pulse_at[1] - k, 2);
      chk("pulse_k21", pulse_at[2] - k, 21);
    end
    chk("single_locked", locked, 1);

    // loss of lock on random data
    for (int i = 0; i < 300 && ms == 2; i++) begin
      cycle(1'b0, 1'b1, 1'(($urandom_range(0, 1))), 1'b0);
      idle();
    end
    idle();
    chk("unlock_state", state, 0);
    chk("unlock_err_min", (err_cnt >= 16), 1);
    e0 = m_err;
    phase_base = sample_idx; rise_at = -1;
    run_clean(85, 1'b0);
    idle();
    chk("relock_sample", rise_at, 85);
    chk("relock_err_retained", err_cnt, e0);

    // clr coincident with a mismatching locked sample
    next_tx(b);
    cycle(1'b0, 1'b1, ~b, 1'b1);
    idle();
    chk("clr_err_cnt", err_cnt, 1);
    chk("clr_bit_cnt", bit_cnt, 1);
    run_clean(30, 1'b0);

    // clk_en held low: nothing moves
    s_err = m_err; s_bits = m_bits;
    for (int i = 0; i < 50; i++) idle();
    chk("hold_err_cnt", err_cnt, s_err);
    chk("hold_bit_cnt", bit_cnt, s_bits);
    chk("hold_state", state, 2);

    // inverted polarity never locks
    do_reset();
    idle();
    ever_locked = 1'b0; max_state = 0;
    run_clean(10000, 1'b1);
    idle();
    chk("inv_never_locked", ever_locked, 0);
    chk("inv_max_state", max_state, 1);
    chk("inv_state_acq", state, 1);

    idle();
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
